// File: rtl/split_demux5_5b.sv
// Clocked 1-to-5 token splitter: FIFO-buffered upstream drive/free, one token dispatched at a time.
// Optional broadcast (sel=7 drives all five channels) is enabled by defining SPLIT_BCAST_EN.
module split_demux5_5b #(
    parameter int DW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_drive,
    input  logic [2:0]    i_sel,
    input  logic [DW-1:0] i_data,
    output logic          o_free,
    output logic          o_drive0,
    output logic          o_drive1,
    output logic          o_drive2,
    output logic          o_drive3,
    output logic          o_drive4,
    output logic [DW-1:0] o_data0,
    output logic [DW-1:0] o_data1,
    output logic [DW-1:0] o_data2,
    output logic [DW-1:0] o_data3,
    output logic [DW-1:0] o_data4,
    input  logic          i_free0,
    input  logic          i_free1,
    input  logic          i_free2,
    input  logic          i_free3,
    input  logic          i_free4,
    output logic          o_busy,
    output logic          o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef struct packed {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } entry_t;

    function automatic logic legal(input logic [2:0] s);
`ifdef SPLIT_BCAST_EN
        return (s < 3'd5) || (s == 3'd7);
`else
        return s < 3'd5;
`endif
    endfunction

    function automatic logic [4:0] dest(input logic [2:0] s);
        return (s == 3'd7) ? 5'h1f : (5'd1 << s);
    endfunction

    // Assertion is asynchronous; release reaches the datapath two edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, count;
    logic [PW:0]   occ_after;
    logic [4:0]    drive_q, drive_d, want_q, want_d, free_in, bad;
    logic [DW-1:0] data_q [5];
    logic          free_q, free_d, owed_q, owed_d, err_q, err_d;
    logic          wr, pop, issue, drop, done, empty;
    entry_t        mem_q [DEPTH];
    entry_t        inc, head, nxt, cand;
`ifdef SPLIT_BCAST_EN
    logic [4:0]    mask_q, mask_d, hit;
`endif

    assign free_in = {i_free4, i_free3, i_free2, i_free1, i_free0};
    assign inc     = '{sel: i_sel, data: i_data};
    assign wr      = i_drive & ~owed_q;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign nxt     = mem_q[AW'(rd_ptr_q[AW-1:0] + 1'b1)];

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        want_d  = want_q;
        drive_d = '0;
        issue   = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;
        done    = 1'b0;
        cand    = '0;
        bad     = free_in;
`ifdef SPLIT_BCAST_EN
        mask_d  = mask_q;
        hit     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (legal(head.sel)) begin
                        issue = 1'b1;
                        cand  = head;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end else if (wr && legal(i_sel)) begin
                    issue = 1'b1;
                    cand  = inc;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
`ifdef SPLIT_BCAST_EN
                hit    = free_in & want_q & ~mask_q;
                bad    = free_in & ~hit;
                mask_d = mask_q | hit;
                done   = (mask_d == want_q);
`else
                done   = |(free_in & want_q);
                bad    = free_in & ~want_q;
`endif
                if (done) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                    // The follow-on token may be the one being written this same cycle.
                    if (count > PW'(1)) begin
                        if (legal(nxt.sel)) begin
                            issue = 1'b1;
                            cand  = nxt;
                        end
                    end else if (wr && legal(i_sel)) begin
                        issue = 1'b1;
                        cand  = inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = ISSUE;
            drive_d = dest(cand.sel);
            want_d  = drive_d;
`ifdef SPLIT_BCAST_EN
            mask_d  = '0;
`endif
        end
    end

    always_comb begin
        occ_after = {1'b0, count} + (PW+1)'(wr) - (PW+1)'(pop);
        free_d    = 1'b0;
        owed_d    = owed_q;
        if (wr && occ_after < (PW+1)'(DEPTH)) begin
            free_d = 1'b1;
        end else if (wr) begin
            owed_d = 1'b1;
        end else if (pop && owed_q) begin
            free_d = 1'b1;
            owed_d = 1'b0;
        end
        err_d = err_q | (i_drive & owed_q) | drop | (|bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drive_q  <= '0;
            want_q   <= '0;
            free_q   <= 1'b0;
            owed_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '{default: '0};
`ifdef SPLIT_BCAST_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            drive_q <= drive_d;
            want_q  <= want_d;
            free_q  <= free_d;
            owed_q  <= owed_d;
            err_q   <= err_d;
`ifdef SPLIT_BCAST_EN
            mask_q  <= mask_d;
`endif
            if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            for (int n = 0; n < 5; n++) begin
                if (drive_d[n]) data_q[n] <= cand.data;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q[AW-1:0]] <= inc;
    end

    assign o_free   = free_q;
    assign o_err    = err_q;
    assign o_busy   = !empty || (state_q != IDLE);
    assign o_drive0 = drive_q[0];
    assign o_drive1 = drive_q[1];
    assign o_drive2 = drive_q[2];
    assign o_drive3 = drive_q[3];
    assign o_drive4 = drive_q[4];
    assign o_data0  = data_q[0];
    assign o_data1  = data_q[1];
    assign o_data2  = data_q[2];
    assign o_data3  = data_q[3];
    assign o_data4  = data_q[4];
endmodule

// File: tb/tb_split_demux5_5b.sv
// Self-checking bench for split_demux5_5b: vector table plus hand sequences, drive scoreboard.
module tb_split_demux5_5b;
    localparam int DW = 5;

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
        int            delay;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [4:0]    mask;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_drive = 1'b0;
    logic [2:0]    i_sel = '0;
    logic [DW-1:0] i_data = '0;
    logic [4:0]    free_vec = '0;
    logic          o_free, o_busy, o_err;
    logic [4:0]    drv;
    logic [DW-1:0] dat [5];
    logic [DW-1:0] model [5];
    exp_t          sb [$];
    vec_t          vecs [8];
    int            n_checks = 0;
    int            n_err = 0;

    split_demux5_5b #(.DW(DW), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
        .o_free(o_free),
        .o_drive0(drv[0]), .o_drive1(drv[1]), .o_drive2(drv[2]), .o_drive3(drv[3]), .o_drive4(drv[4]),
        .o_data0(dat[0]), .o_data1(dat[1]), .o_data2(dat[2]), .o_data3(dat[3]), .o_data4(dat[4]),
        .i_free0(free_vec[0]), .i_free1(free_vec[1]), .i_free2(free_vec[2]),
        .i_free3(free_vec[3]), .i_free4(free_vec[4]),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] exp_mask(input logic [2:0] s);
        if (s < 3'd5) return 5'd1 << s;
`ifdef SPLIT_BCAST_EN
        if (s == 3'd7) return 5'h1f;
`endif
        return 5'h00;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < 5; n++) model[n] = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        i_drive  = 1'b0;
        free_vec = '0;
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        clear_model();
    endtask

    task automatic send(input logic [2:0] s, input logic [DW-1:0] d);
        logic [4:0] m;
        m       = exp_mask(s);
        i_drive = 1'b1;
        i_sel   = s;
        i_data  = d;
        if (m != 5'h00) sb.push_back('{mask: m, data: d});
    endtask

    task automatic check_data(input string name);
        for (int n = 0; n < 5; n++) check(name, 32'(dat[n]), 32'(model[n]));
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] m;
        m = exp_mask(v.sel);
        send(v.sel, v.data);
        tick();
        i_drive = 1'b0;
        check("free_pulse", 32'(o_free), 32'd1);
        if (m != 5'h00) begin
            repeat (v.delay) tick();
            free_vec = m;
            tick();
            free_vec = '0;
            for (int n = 0; n < 5; n++) if (m[n]) model[n] = v.data;
        end else begin
            tick();
        end
        check("busy_done", 32'(o_busy), 32'd0);
        check("err_flag", 32'(o_err), 32'(v.exp_err));
        check_data("data_hold");
    endtask

    // Every drive pulse must match the oldest token still awaiting dispatch.
    always @(negedge clk) begin
        exp_t e;
        if (drv != 5'h00) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_drive: got mask %b, expected no drive at %0t", drv, $time);
            end else begin
                e = sb.pop_front();
                check("drive_mask", 32'(drv), 32'(e.mask));
                for (int n = 0; n < 5; n++) if (e.mask[n]) check("drive_data", 32'(dat[n]), 32'(e.data));
            end
        end
    end

    initial begin
        vecs[0] = '{sel: 3'd2, data: 5'h15, delay: 3, exp_err: 1'b0};
        vecs[1] = '{sel: 3'd0, data: 5'h0A, delay: 1, exp_err: 1'b0};
        vecs[2] = '{sel: 3'd4, data: 5'h1F, delay: 2, exp_err: 1'b0};
        vecs[3] = '{sel: 3'd1, data: 5'h00, delay: 5, exp_err: 1'b0};
        vecs[4] = '{sel: 3'd3, data: 5'h11, delay: 1, exp_err: 1'b0};
        vecs[5] = '{sel: 3'd2, data: 5'h07, delay: 2, exp_err: 1'b0};
        vecs[6] = '{sel: 3'd5, data: 5'h1C, delay: 1, exp_err: 1'b1};
        vecs[7] = '{sel: 3'd6, data: 5'h03, delay: 1, exp_err: 1'b1};

        do_reset();
        check("rst_free", 32'(o_free), 32'd0);
        check("rst_drive", 32'(drv), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check_data("rst_data");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_err) do_reset();
            run_vec(vecs[i]);
        end

        // Back-to-back: second free deferred until channel 0 completes.
        do_reset();
        send(3'd0, 5'h01);
        tick();
        i_drive = 1'b0;
        check("b2b_free1", 32'(o_free), 32'd1);
        tick();
        send(3'd4, 5'h1E);
        tick();
        i_drive = 1'b0;
        check("b2b_free_deferred", 32'(o_free), 32'd0);
        check("b2b_drive4_early", 32'(drv[4]), 32'd0);
        repeat (4) tick();
        free_vec = 5'b00001;
        tick();
        free_vec = '0;
        check("b2b_free2", 32'(o_free), 32'd1);
        check("b2b_drive4", 32'(drv[4]), 32'd1);
        tick();
        free_vec = 5'b10000;
        tick();
        free_vec = '0;
        check("b2b_busy", 32'(o_busy), 32'd0);
        check("b2b_err", 32'(o_err), 32'd0);

        // Spurious free on channel 3 while channel 1 is outstanding.
        do_reset();
        send(3'd1, 5'h09);
        tick();
        i_drive = 1'b0;
        tick();
        free_vec = 5'b01000;
        tick();
        free_vec = '0;
        check("spur_err", 32'(o_err), 32'd1);
        check("spur_busy", 32'(o_busy), 32'd1);
        free_vec = 5'b00010;
        tick();
        free_vec = '0;
        check("spur_done", 32'(o_busy), 32'd0);
        check("spur_data1", 32'(dat[1]), 32'h09);

        // Broadcast token.
        do_reset();
        send(3'd7, 5'h0A);
        tick();
        i_drive = 1'b0;
        check("bc_free", 32'(o_free), 32'd1);
        tick();
`ifdef SPLIT_BCAST_EN
        free_vec = 5'b10000; tick();
        free_vec = 5'b00010; tick();
        free_vec = 5'b00101; tick();
        free_vec = '0;
        check("bc_busy_partial", 32'(o_busy), 32'd1);
        check("bc_err_partial", 32'(o_err), 32'd0);
        free_vec = 5'b01000; tick();
        free_vec = '0;
        check("bc_busy_done", 32'(o_busy), 32'd0);
        check("bc_err", 32'(o_err), 32'd0);
        for (int n = 0; n < 5; n++) model[n] = 5'h0A;
        check_data("bc_data");
`else
        check("bc_illegal_err", 32'(o_err), 32'd1);
        check("bc_illegal_busy", 32'(o_busy), 32'd0);
        check_data("bc_illegal_data");
`endif

        // Reset asserted while waiting on channel 3.
        do_reset();
        send(3'd3, 5'h07);
        tick();
        i_drive = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rstw_drive", 32'(drv), 32'd0);
        check("rstw_data3", 32'(dat[3]), 32'd0);
        check("rstw_free", 32'(o_free), 32'd0);
        check("rstw_busy", 32'(o_busy), 32'd0);
        check("rstw_err", 32'(o_err), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        clear_model();
        run_vec('{sel: 3'd1, data: 5'h0C, delay: 2, exp_err: 1'b0});

        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
